// File: rtl/calc_pkg.sv
// Shared constants and state encoding for the calculator's ASCII operand path.
package calc_pkg;

  localparam logic [7:0] ASC_BS  = 8'h08;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_ESC = 8'h1B;
  localparam logic [7:0] ASC_0   = 8'h30;
  localparam logic [7:0] ASC_9   = 8'h39;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASC_0) && (c <= ASC_9);
  endfunction

endpackage

// File: rtl/mul10_add.sv
// Combinational acc*10 + digit using shift-add, no multiplier.
module mul10_add #(
  parameter int W = 20
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   digit,
  output logic [W-1:0] result
);

  assign result = (acc << 3) + (acc << 1) + {{(W-4){1'b0}}, digit};

endmodule

// File: rtl/ascii_to_bin.sv
// Buffers typed decimal ASCII digits as BCD and converts them MSB-first into
// an unsigned WIDTH-bit operand when Enter is received.
module ascii_to_bin
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             dataReady,
  input  logic [7:0]       asciiIn,
  output logic             busy,
  output logic [2:0]       digitCount,
  output logic [WIDTH-1:0] valueOut,
  output logic             valueValid,
  output logic             overflow
);

  localparam int         ACC_W   = WIDTH + 4;
  localparam logic [2:0] MAX_CNT = 3'(MAX_DIGITS);

  state_t             state_r;
  logic [3:0]         buf_r [MAX_DIGITS];
  logic [2:0]         digit_count_r;
  logic [2:0]         conv_idx_r;
  logic               drop_r;
  logic               busy_r;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   acc_next_s;
  logic [3:0]         digit_s;
  logic [WIDTH-1:0]   value_r;
  logic               valid_r;
  logic               overflow_r;
  logic               overflow_s;

  // Select the digit being folded in; the index runs one past the last digit once conversion ends.
  always_comb begin
    digit_s = 4'd0;
    if (conv_idx_r < MAX_CNT) begin
      digit_s = buf_r[conv_idx_r];
    end else begin
      digit_s = 4'd0;
    end
  end

  mul10_add #(.W(ACC_W)) u_mul10_add (
    .acc    (acc_r),
    .digit  (digit_s),
    .result (acc_next_s)
  );

  assign overflow_s = drop_r || (acc_r[ACC_W-1:WIDTH] != 4'd0);

  // Editing, conversion sequencing and result registration.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      for (int i = 0; i < MAX_DIGITS; i++) buf_r[i] <= 4'd0;
      digit_count_r <= 3'd0;
      conv_idx_r    <= 3'd0;
      drop_r        <= 1'b0;
      busy_r        <= 1'b0;
      acc_r         <= '0;
      value_r       <= '0;
      valid_r       <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (dataReady) begin
            if (is_digit(asciiIn)) begin
              if (digit_count_r < MAX_CNT) begin
                buf_r[digit_count_r] <= asciiIn[3:0];
                digit_count_r        <= digit_count_r + 3'd1;
              end else begin
                drop_r <= 1'b1;
              end
            end else if (asciiIn == ASC_BS) begin
              if (digit_count_r != 3'd0) digit_count_r <= digit_count_r - 3'd1;
            end else if (asciiIn == ASC_ESC) begin
              digit_count_r <= 3'd0;
              drop_r        <= 1'b0;
            end else if (asciiIn == ASC_CR) begin
              acc_r      <= '0;
              conv_idx_r <= 3'd0;
              busy_r     <= 1'b1;
              state_r    <= (digit_count_r != 3'd0) ? ST_CONV : ST_FIN;
            end
          end
        end
        ST_CONV: begin
          acc_r      <= acc_next_s;
          conv_idx_r <= conv_idx_r + 3'd1;
          if (conv_idx_r == digit_count_r - 3'd1) state_r <= ST_FIN;
        end
        ST_FIN: begin
          value_r       <= overflow_s ? {WIDTH{1'b1}} : acc_r[WIDTH-1:0];
          overflow_r    <= overflow_s;
          valid_r       <= 1'b1;
          for (int i = 0; i < MAX_DIGITS; i++) buf_r[i] <= 4'd0;
          digit_count_r <= 3'd0;
          drop_r        <= 1'b0;
          busy_r        <= 1'b0;
          state_r       <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_r;
  assign digitCount = digit_count_r;
  assign valueOut   = value_r;
  assign valueValid = valid_r;
  assign overflow   = overflow_r;

endmodule
